scytale_decryption: RTL and testbench

- Downstream consumer of the decryption register file's `scytale_key` output; sits in the scytale branch of the decryption datapath.
- Buffers an incoming ciphertext stream of characters until the start token arrives.
- Then emits the plaintext one character per cycle, reading the buffer in columnar (scytale) order.
- Asserts `busy` while emitting so the upstream source stalls.

---
 rtl/scytale_decryption_if.sv | 23 ++
 rtl/scytale_decryption.sv | 104 ++++++++++
 tb/tb_scytale_decryption.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/scytale_decryption_if.sv
// rtl/scytale_decryption_if.sv - ciphertext in / plaintext out handshake bundle for the scytale decrypter
interface scytale_decryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 16
);
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key;
    logic                 busy;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;
    logic                 error_o;

    modport master (
        output data_i, valid_i, key,
        input  busy, data_o, valid_o, error_o
    );

    modport slave (
        input  data_i, valid_i, key,
        output busy, data_o, valid_o, error_o
    );
endinterface

// File: rtl/scytale_decryption.sv
// rtl/scytale_decryption.sv - buffers ciphertext until token, then emits it in scytale column order
// Optional length check (error_o) enabled by defining SCYTALE_LEN_CHECK_EN.
module scytale_decryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 16,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
    input logic                clk,
    input logic                rst_n,
    scytale_decryption_if.slave bus
);
    localparam int               ADDR_W  = $clog2(MAX_NOF_CHARS);
    localparam int               PTR_W   = $clog2(MAX_NOF_CHARS + 1);
    localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_NOF_CHARS);
    localparam logic [15:0]      MAX_LEN = 16'(MAX_NOF_CHARS);

    typedef enum logic {COLLECT, DECRYPT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];
    logic [7:0]         key_n_q, key_m_q, row_q, col_q;
    logic [15:0]        len_q, out_cnt_q;
    logic               len_ok_q;
    logic [15:0]        tok_len, rd_addr;
    logic               tok_len_ok;

    always_comb begin
        tok_len    = 16'(bus.key[15:8]) * 16'(bus.key[7:0]);
        tok_len_ok = (tok_len != 16'd0) && (tok_len <= MAX_LEN)
`ifdef SCYTALE_LEN_CHECK_EN
                     && (16'(wr_ptr) == tok_len)
`endif
                     ;
        // row/col counters replace the k mod m / k div m of the columnar read
        rd_addr    = 16'(row_q) * 16'(key_n_q) + 16'(col_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= COLLECT;
            wr_ptr      <= '0;
            bus.busy    <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
`ifdef SCYTALE_LEN_CHECK_EN
            bus.error_o <= 1'b0;
`endif
        end else begin
`ifdef SCYTALE_LEN_CHECK_EN
            bus.error_o <= 1'b0;
`endif
            case (state)
                COLLECT: begin
                    bus.valid_o <= 1'b0;
                    if (bus.valid_i) begin
                        if (bus.data_i == START_DECRYPTION_TOKEN) begin
                            key_n_q   <= bus.key[15:8];
                            key_m_q   <= bus.key[7:0];
                            len_q     <= tok_len;
                            len_ok_q  <= tok_len_ok;
                            row_q     <= 8'd0;
                            col_q     <= 8'd0;
                            out_cnt_q <= 16'd0;
                            bus.busy  <= 1'b1;
                            state     <= DECRYPT;
`ifdef SCYTALE_LEN_CHECK_EN
                            bus.error_o <= !tok_len_ok;
`endif
                        end else if (wr_ptr < MAX_PTR) begin
                            mem[ADDR_W'(wr_ptr)] <= bus.data_i;
                            wr_ptr               <= wr_ptr + 1'b1;
                        end
                    end
                end
                DECRYPT: begin
                    if (len_ok_q && (out_cnt_q < len_q)) begin
                        bus.valid_o <= 1'b1;
                        // positions never received read back as zero padding
                        bus.data_o  <= (rd_addr < 16'(wr_ptr)) ? mem[ADDR_W'(rd_addr)] : '0;
                        out_cnt_q   <= out_cnt_q + 16'd1;
                        if (row_q == key_m_q - 8'd1) begin
                            row_q <= 8'd0;
                            col_q <= col_q + 8'd1;
                        end else begin
                            row_q <= row_q + 8'd1;
                        end
                    end else begin
                        bus.valid_o <= 1'b0;
                        bus.busy    <= 1'b0;
                        wr_ptr      <= '0;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifndef SCYTALE_LEN_CHECK_EN
    assign bus.error_o = 1'b0;
`endif
endmodule

// File: tb/tb_scytale_decryption.sv
// tb/tb_scytale_decryption.sv - directed-vector self-checking bench for scytale_decryption
module tb_scytale_decryption;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt, err_cnt;
    bq_t  out_q;

    always #5 clk = ~clk;

    scytale_decryption_if #(.D_WIDTH(8), .KEY_WIDTH(16)) bus ();

    scytale_decryption dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.busy)    busy_cnt++;
        if (bus.error_o) err_cnt++;
        if (bus.valid_o) out_q.push_back(bus.data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic clear_mon();
        busy_cnt = 0;
        err_cnt  = 0;
        out_q.delete();
    endtask

    task automatic send_chars(input logic [15:0] k, input bq_t din);
        bus.key = k;
        foreach (din[i]) begin
            bus.data_i  = din[i];
            bus.valid_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.data_i  = 8'hFA;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
    endtask

    task automatic check_out(input string tag, input bq_t exp);
        check({tag, "_nout"}, out_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_q.size(); i++)
            check($sformatf("%s_out%0d", tag, i), out_q[i], exp[i]);
    endtask

    task automatic run_msg(input string tag, input logic [15:0] k, input bq_t din, input bq_t exp,
                           input int exp_busy, input int exp_err, input bit inject);
        bit done = 1'b0;
        clear_mon();
        send_chars(k, din);
        for (int i = 0; i < 300 && !done; i++) begin
            if (inject && i == 0) begin
                bus.data_i  = 8'h41;
                bus.valid_i = 1'b1;
                bus.key     = 16'h0101;
            end
            @(posedge clk); #1;
            bus.valid_i = 1'b0;
            if (!bus.busy) done = 1'b1;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_wrptr"}, dut.wr_ptr, 0);
        check_out(tag, exp);
    endtask

    initial begin
        bq_t big, big_exp, none;
        int  len_err;
        rst_n       = 1'b0;
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b0;
        bus.key     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_err", bus.error_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_msg("m1", 16'h0203, s2q("ABCDEF"), s2q("ACEBDF"), 7, 0, 1'b0);
        check("hold_data", bus.data_o, 8'h46);
        run_msg("m2", 16'h0302, s2q("ABCDEF"), s2q("ADBECF"), 7, 0, 1'b0);
        run_msg("inj", 16'h0203, s2q("ABCDEF"), s2q("ACEBDF"), 7, 0, 1'b1);
        run_msg("after_inj", 16'h0302, s2q("ABCDEF"), s2q("ADBECF"), 7, 0, 1'b0);

`ifdef SCYTALE_LEN_CHECK_EN
        len_err = 1;
`else
        len_err = 0;
`endif
        run_msg("k0", 16'h0000, none, none, 1, len_err, 1'b0);
        run_msg("kff", 16'hFFFF, none, none, 1, len_err, 1'b0);

        for (int i = 0; i < 52; i++) big.push_back(8'(i + 1));
        for (int k = 0; k < 50; k++) big_exp.push_back(8'((k % 5) * 10 + k / 5 + 1));
        run_msg("big", 16'h0A05, big, big_exp, 51, 0, 1'b0);

`ifdef SCYTALE_LEN_CHECK_EN
        run_msg("short", 16'h0203, s2q("ABCD"), none, 1, 1, 1'b0);
`else
        begin
            bq_t sexp;
            sexp = '{8'h41, 8'h43, 8'h00, 8'h42, 8'h44, 8'h00};
            run_msg("short", 16'h0203, s2q("ABCD"), sexp, 7, 0, 1'b0);
        end
`endif

        clear_mon();
        send_chars(16'h0203, s2q("ABCDEF"));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_valid", bus.valid_o, 1);
        check("mid_data", bus.data_o, 8'h45);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_nout", out_q.size(), 3);
        run_msg("post_rst", 16'h0203, s2q("ABCDEF"), s2q("ACEBDF"), 7, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
